// File: rtl/emif_axi_fixed_burst_shim.sv
// Per-channel AXI-MM shim: calibration gating, outstanding caps, and FIXED bursts
// split into single-beat INCR transactions with responses merged back.
module emif_axi_fixed_burst_shim #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 8,
  parameter int USER_W          = 1,
  parameter int MAX_OUTSTANDING = 16,
  parameter int SPLIT_FIXED     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cal_done,
  // upstream write address
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [ID_W-1:0]          s_awid,
  input  logic [ADDR_W-1:0]        s_awaddr,
  input  logic [7:0]               s_awlen,
  input  logic [2:0]               s_awsize,
  input  logic [1:0]               s_awburst,
  input  logic                     s_awlock,
  input  logic [2:0]               s_awprot,
  input  logic [USER_W-1:0]        s_awuser,
  input  logic [3:0]               s_awqos,
  // upstream write data / response
  input  logic                     s_wvalid,
  output logic                     s_wready,
  input  logic [DATA_W-1:0]        s_wdata,
  input  logic [DATA_W/8-1:0]      s_wstrb,
  input  logic                     s_wlast,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  output logic [ID_W-1:0]          s_bid,
  output logic [1:0]               s_bresp,
  // upstream read address / data
  input  logic                     s_arvalid,
  output logic                     s_arready,
  input  logic [ID_W-1:0]          s_arid,
  input  logic [ADDR_W-1:0]        s_araddr,
  input  logic [7:0]               s_arlen,
  input  logic [2:0]               s_arsize,
  input  logic [1:0]               s_arburst,
  input  logic                     s_arlock,
  input  logic [2:0]               s_arprot,
  input  logic [USER_W-1:0]        s_aruser,
  input  logic [3:0]               s_arqos,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [ID_W-1:0]          s_rid,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rlast,
  // downstream write address
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [ID_W-1:0]          m_awid,
  output logic [ADDR_W-1:0]        m_awaddr,
  output logic [7:0]               m_awlen,
  output logic [2:0]               m_awsize,
  output logic [1:0]               m_awburst,
  output logic                     m_awlock,
  output logic [2:0]               m_awprot,
  output logic [USER_W-1:0]        m_awuser,
  output logic [3:0]               m_awqos,
  // downstream write data / response
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     m_wlast,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  input  logic [ID_W-1:0]          m_bid,
  input  logic [1:0]               m_bresp,
  // downstream read address / data
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ID_W-1:0]          m_arid,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic                     m_arlock,
  output logic [2:0]               m_arprot,
  output logic [USER_W-1:0]        m_aruser,
  output logic [3:0]               m_arqos,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [ID_W-1:0]          m_rid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] rd_outstanding,
  output logic [2:0]               wr_state_o,
  output logic [2:0]               rd_state_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Handshake rule on every channel: a beat transfers on a rising clk edge where
  // valid && ready; valid never waits on ready, and payload is stable while valid.
  typedef enum logic [2:0] {ST_IDLE, ST_PASS, ST_DRAIN, ST_SPLIT, ST_COLLECT} state_e;

  // ---------------- write direction ----------------
  state_e               wr_state_q;
  logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d, wr_pend_q, wr_pend_d;
  logic [ID_W-1:0]      wr_id_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [7:0]           wr_len_q, wr_brcvd_q;
  logic [8:0]           wr_issued_q;
  logic [2:0]           wr_size_q, wr_prot_q;
  logic                 wr_lock_q, wr_wwait_q;
  logic [USER_W-1:0]    wr_user_q;
  logic [3:0]           wr_qos_q;
  logic [1:0]           wr_bmax_q, wr_bmax_d;

  logic wr_pass_mode, wr_split_act, wr_room, wr_is_fixed, wr_bfinal;
  logic wr_inc, wr_dec, wr_pend_inc, wr_pend_dec;

  assign wr_pass_mode = (wr_state_q == ST_IDLE) || (wr_state_q == ST_PASS);
  assign wr_split_act = (wr_state_q == ST_SPLIT) || (wr_state_q == ST_COLLECT);
  assign wr_room      = (wr_cnt_q != CNT_MAX);
  assign wr_is_fixed  = (SPLIT_FIXED != 0) && (s_awburst == 2'b00);
  assign wr_bfinal    = (wr_brcvd_q == wr_len_q);
  assign wr_bmax_d    = (m_bresp > wr_bmax_q) ? m_bresp : wr_bmax_q;

  always_comb begin
    s_awready = 1'b0;
    m_awvalid = 1'b0;
    m_awid    = s_awid;
    m_awaddr  = s_awaddr;
    m_awlen   = s_awlen;
    m_awsize  = s_awsize;
    m_awburst = (s_awburst == 2'b00) ? 2'b01 : s_awburst;
    m_awlock  = s_awlock;
    m_awprot  = s_awprot;
    m_awuser  = s_awuser;
    m_awqos   = s_awqos;
    if (wr_pass_mode) begin
      if (wr_is_fixed) begin
        s_awready = s_awvalid && cal_done && wr_room;
      end else begin
        m_awvalid = s_awvalid && cal_done && wr_room;
        s_awready = m_awready && cal_done && wr_room;
      end
    end else if (wr_state_q == ST_SPLIT) begin
      m_awvalid = !wr_wwait_q && wr_room;
      m_awid    = wr_id_q;
      m_awaddr  = wr_addr_q;
      m_awlen   = 8'd0;
      m_awsize  = wr_size_q;
      m_awburst = 2'b01;
      m_awlock  = wr_lock_q;
      m_awprot  = wr_prot_q;
      m_awuser  = wr_user_q;
      m_awqos   = wr_qos_q;
    end
  end

  // While draining, only W beats owed to already-issued pass bursts may flow;
  // the FIXED burst's beats queue behind them upstream.
  always_comb begin
    m_wvalid = 1'b0;
    s_wready = 1'b0;
    m_wdata  = s_wdata;
    m_wstrb  = s_wstrb;
    m_wlast  = s_wlast;
    if (wr_pass_mode || (wr_state_q == ST_DRAIN && wr_pend_q != '0)) begin
      m_wvalid = s_wvalid;
      s_wready = m_wready;
    end else if (wr_state_q == ST_SPLIT && wr_wwait_q) begin
      m_wvalid = s_wvalid;
      s_wready = m_wready;
      m_wlast  = 1'b1;
    end
  end

  always_comb begin
    s_bvalid = m_bvalid;
    m_bready = s_bready;
    s_bid    = m_bid;
    s_bresp  = m_bresp;
    if (wr_split_act) begin
      s_bvalid = m_bvalid && wr_bfinal;
      m_bready = wr_bfinal ? s_bready : 1'b1;
      s_bresp  = wr_bmax_d;
    end
  end

  assign wr_inc      = m_awvalid && m_awready;
  assign wr_dec      = m_bvalid && m_bready;
  assign wr_cnt_d    = wr_cnt_q + CNT_W'(wr_inc) - CNT_W'(wr_dec);
  assign wr_pend_inc = wr_inc && wr_pass_mode;
  assign wr_pend_dec = m_wvalid && m_wready && m_wlast && !wr_split_act &&
                       (wr_pend_q != '0 || wr_pend_inc);
  assign wr_pend_d   = wr_pend_q + CNT_W'(wr_pend_inc) - CNT_W'(wr_pend_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= ST_IDLE;
      wr_cnt_q    <= '0;
      wr_pend_q   <= '0;
      wr_id_q     <= '0;
      wr_addr_q   <= '0;
      wr_len_q    <= '0;
      wr_size_q   <= '0;
      wr_lock_q   <= 1'b0;
      wr_prot_q   <= '0;
      wr_user_q   <= '0;
      wr_qos_q    <= '0;
      wr_issued_q <= '0;
      wr_brcvd_q  <= '0;
      wr_bmax_q   <= '0;
      wr_wwait_q  <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
      case (wr_state_q)
        ST_IDLE, ST_PASS: begin
          if (s_awvalid && s_awready && wr_is_fixed) begin
            wr_id_q     <= s_awid;
            wr_addr_q   <= s_awaddr;
            wr_len_q    <= s_awlen;
            wr_size_q   <= s_awsize;
            wr_lock_q   <= s_awlock;
            wr_prot_q   <= s_awprot;
            wr_user_q   <= s_awuser;
            wr_qos_q    <= s_awqos;
            wr_issued_q <= '0;
            wr_brcvd_q  <= '0;
            wr_bmax_q   <= '0;
            wr_wwait_q  <= 1'b0;
            wr_state_q  <= ST_DRAIN;
          end else begin
            wr_state_q <= (wr_cnt_d != '0) ? ST_PASS : ST_IDLE;
          end
        end
        ST_DRAIN: if (wr_cnt_q == '0) wr_state_q <= ST_SPLIT;
        ST_SPLIT: begin
          if (m_awvalid && m_awready) begin
            wr_issued_q <= wr_issued_q + 9'd1;
            wr_wwait_q  <= 1'b1;
          end
          if (wr_wwait_q && m_wvalid && m_wready) begin
            wr_wwait_q <= 1'b0;
            if (wr_issued_q == {1'b0, wr_len_q} + 9'd1) wr_state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: if (s_bvalid && s_bready) wr_state_q <= ST_IDLE;
        default: wr_state_q <= ST_IDLE;
      endcase
      if (wr_split_act && m_bvalid && m_bready) begin
        wr_brcvd_q <= wr_brcvd_q + 8'd1;
        wr_bmax_q  <= wr_bmax_d;
      end
    end
  end

  // ---------------- read direction ----------------
  state_e               rd_state_q;
  logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
  logic [ID_W-1:0]      rd_id_q;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic [7:0]           rd_len_q, rd_issued_q, rd_rcvd_q;
  logic [2:0]           rd_size_q, rd_prot_q;
  logic                 rd_lock_q;
  logic [USER_W-1:0]    rd_user_q;
  logic [3:0]           rd_qos_q;

  logic rd_pass_mode, rd_split_act, rd_room, rd_is_fixed, rd_inc, rd_dec;

  assign rd_pass_mode = (rd_state_q == ST_IDLE) || (rd_state_q == ST_PASS);
  assign rd_split_act = (rd_state_q == ST_SPLIT) || (rd_state_q == ST_COLLECT);
  assign rd_room      = (rd_cnt_q != CNT_MAX);
  assign rd_is_fixed  = (SPLIT_FIXED != 0) && (s_arburst == 2'b00);

  always_comb begin
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    m_arid    = s_arid;
    m_araddr  = s_araddr;
    m_arlen   = s_arlen;
    m_arsize  = s_arsize;
    m_arburst = (s_arburst == 2'b00) ? 2'b01 : s_arburst;
    m_arlock  = s_arlock;
    m_arprot  = s_arprot;
    m_aruser  = s_aruser;
    m_arqos   = s_arqos;
    if (rd_pass_mode) begin
      if (rd_is_fixed) begin
        s_arready = s_arvalid && cal_done && rd_room;
      end else begin
        m_arvalid = s_arvalid && cal_done && rd_room;
        s_arready = m_arready && cal_done && rd_room;
      end
    end else if (rd_state_q == ST_SPLIT) begin
      m_arvalid = rd_room;
      m_arid    = rd_id_q;
      m_araddr  = rd_addr_q;
      m_arlen   = 8'd0;
      m_arsize  = rd_size_q;
      m_arburst = 2'b01;
      m_arlock  = rd_lock_q;
      m_arprot  = rd_prot_q;
      m_aruser  = rd_user_q;
      m_arqos   = rd_qos_q;
    end
  end

  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = rd_split_act ? (rd_rcvd_q == rd_len_q) : m_rlast;

  assign rd_inc   = m_arvalid && m_arready;
  assign rd_dec   = m_rvalid && m_rready && m_rlast;
  assign rd_cnt_d = rd_cnt_q + CNT_W'(rd_inc) - CNT_W'(rd_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q  <= ST_IDLE;
      rd_cnt_q    <= '0;
      rd_id_q     <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= '0;
      rd_size_q   <= '0;
      rd_lock_q   <= 1'b0;
      rd_prot_q   <= '0;
      rd_user_q   <= '0;
      rd_qos_q    <= '0;
      rd_issued_q <= '0;
      rd_rcvd_q   <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      case (rd_state_q)
        ST_IDLE, ST_PASS: begin
          if (s_arvalid && s_arready && rd_is_fixed) begin
            rd_id_q     <= s_arid;
            rd_addr_q   <= s_araddr;
            rd_len_q    <= s_arlen;
            rd_size_q   <= s_arsize;
            rd_lock_q   <= s_arlock;
            rd_prot_q   <= s_arprot;
            rd_user_q   <= s_aruser;
            rd_qos_q    <= s_arqos;
            rd_issued_q <= '0;
            rd_rcvd_q   <= '0;
            rd_state_q  <= ST_DRAIN;
          end else begin
            rd_state_q <= (rd_cnt_d != '0) ? ST_PASS : ST_IDLE;
          end
        end
        ST_DRAIN: if (rd_cnt_q == '0) rd_state_q <= ST_SPLIT;
        ST_SPLIT: begin
          if (m_arvalid && m_arready) begin
            rd_issued_q <= rd_issued_q + 8'd1;
            if (rd_issued_q == rd_len_q) rd_state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: if (s_rvalid && s_rready && s_rlast) rd_state_q <= ST_IDLE;
        default: rd_state_q <= ST_IDLE;
      endcase
      if (rd_split_act && m_rvalid && m_rready) rd_rcvd_q <= rd_rcvd_q + 8'd1;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign wr_state_o     = wr_state_q;
  assign rd_state_o     = rd_state_q;

endmodule
